// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Package : mdu_defs
// Purpose : Shared definitions for the multiply/divide unit: MDOp encodings
//           and the busy-counter width helper.
// Revision: 1.0 - initial release
// ============================================================================
package mdu_defs;

  localparam int MDOP_W = 3;

  // MDOp encodings; 6 and 7 are reserved and have no effect when issued.
  localparam logic [MDOP_W-1:0] MD_MULT  = 3'd0;
  localparam logic [MDOP_W-1:0] MD_MULTU = 3'd1;
  localparam logic [MDOP_W-1:0] MD_DIV   = 3'd2;
  localparam logic [MDOP_W-1:0] MD_DIVU  = 3'd3;
  localparam logic [MDOP_W-1:0] MD_MTHI  = 3'd4;
  localparam logic [MDOP_W-1:0] MD_MTLO  = 3'd5;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  // Counter width: clog2 of the longer latency plus one, so the load value
  // always fits even when it is an exact power of two.
  function automatic int cnt_width(input int mult_cycles, input int div_cycles);
    int m;
    m = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
    return $clog2(m) + 1;
  endfunction

  localparam int CNT_W = cnt_width(DEF_MULT_CYCLES, DEF_DIV_CYCLES);

endpackage
`default_nettype wire

// File: rtl/mdu_calc.sv
`default_nettype none
// ============================================================================
// Module  : mdu_calc
// Purpose : Combinational 32x32 multiply / divide datapath.
// Ports   : MDOp    - operation code (mdu_defs encodings)
//           A, B    - operands (rs, rt)
//           ResHi   - HI result (product upper word / remainder)
//           ResLo   - LO result (product lower word / quotient)
//           DivZero - DIV/DIVU with B == 0; the result must not be committed
// Revision: 1.0 - initial release
// ============================================================================
module mdu_calc
  import mdu_defs::*;
(
  input  logic [MDOP_W-1:0] MDOp,
  input  logic [31:0]       A,
  input  logic [31:0]       B,
  output logic [31:0]       ResHi,
  output logic [31:0]       ResLo,
  output logic              DivZero
);

  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic               div_ovf;
  logic [31:0]        divisor_s;
  logic [31:0]        divisor_u;
  logic signed [31:0] quot_s;
  logic signed [31:0] rem_s;
  logic [31:0]        quot_u;
  logic [31:0]        rem_u;

  // The low 64 bits of the product of sign-extended operands equal the
  // signed 32x32 product, so one unsigned 64-bit multiply serves both.
  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'b0, A} * {32'b0, B};

  // INT_MIN / -1 overflows; dividing by 1 instead yields exactly the
  // required quotient 0x80000000 and remainder 0. A zero divisor is also
  // replaced by 1 so the datapath never divides by zero.
  assign div_ovf   = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
  assign divisor_s = ((B == 32'd0) || div_ovf) ? 32'd1 : B;
  assign divisor_u = (B == 32'd0) ? 32'd1 : B;

  // SystemVerilog signed / and % truncate toward zero; remainder follows
  // the sign of the dividend.
  assign quot_s = $signed(A) / $signed(divisor_s);
  assign rem_s  = $signed(A) % $signed(divisor_s);
  assign quot_u = A / divisor_u;
  assign rem_u  = A % divisor_u;

  always_comb begin
    ResHi   = 32'd0;
    ResLo   = 32'd0;
    DivZero = 1'b0;
    case (MDOp)
      MD_MULT: begin
        ResHi = prod_s[63:32];
        ResLo = prod_s[31:0];
      end
      MD_MULTU: begin
        ResHi = prod_u[63:32];
        ResLo = prod_u[31:0];
      end
      MD_DIV: begin
        ResHi   = rem_s;
        ResLo   = quot_s;
        DivZero = (B == 32'd0);
      end
      MD_DIVU: begin
        ResHi   = rem_u;
        ResLo   = quot_u;
        DivZero = (B == 32'd0);
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mdu.sv
`default_nettype none
// ============================================================================
// Module  : mdu
// Purpose : EX-stage multi-cycle multiply/divide unit owning HI/LO. Results
//           are computed at issue and committed after a fixed latency.
// Ports   : Clk    - rising-edge clock
//           Rst    - asynchronous active-high reset
//           Start  - issue qualifier for MDOp
//           MDOp   - operation code (mdu_defs encodings)
//           A, B   - forwarded rs / rt operands
//           Cancel - exception flush; kills pending op and same-cycle Start
//           Busy   - operation in flight
//           HI, LO - architectural HI / LO registers
// Revision: 1.0 - initial release
// ============================================================================
module mdu
  import mdu_defs::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  input  logic [MDOP_W-1:0] MDOp,
  input  logic [31:0]       A,
  input  logic [31:0]       B,
  input  logic              Cancel,
  output logic              Busy,
  output logic [31:0]       HI,
  output logic [31:0]       LO
);

  localparam int              CW        = cnt_width(MULT_CYCLES, DIV_CYCLES);
  localparam logic [CW-1:0]   MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0]   DIV_LOAD  = CW'(DIV_CYCLES);

  logic          busy_q,    busy_d;
  logic [CW-1:0] cnt_q,     cnt_d;
  logic [31:0]   hi_q,      hi_d;
  logic [31:0]   lo_q,      lo_d;
  logic [31:0]   pend_hi_q, pend_hi_d;
  logic [31:0]   pend_lo_q, pend_lo_d;
  logic          pend_ok_q, pend_ok_d;   // low for divide-by-zero: no commit

  logic [31:0]   res_hi;
  logic [31:0]   res_lo;
  logic          div_zero;

  mdu_calc u_calc (
    .MDOp    (MDOp),
    .A       (A),
    .B       (B),
    .ResHi   (res_hi),
    .ResLo   (res_lo),
    .DivZero (div_zero)
  );

  always_comb begin
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_ok_d = pend_ok_q;

    if (busy_q) begin
      // Start is ignored while busy. Cancel takes priority over the commit
      // that would otherwise happen on the final count.
      if (Cancel) begin
        busy_d    = 1'b0;
        cnt_d     = '0;
        pend_ok_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          busy_d = 1'b0;
          if (pend_ok_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
    end else if (Start && !Cancel) begin
      case (MDOp)
        MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
          busy_d    = 1'b1;
          cnt_d     = ((MDOp == MD_MULT) || (MDOp == MD_MULTU)) ? MULT_LOAD : DIV_LOAD;
          pend_hi_d = res_hi;
          pend_lo_d = res_lo;
          pend_ok_d = !div_zero;
        end
        MD_MTHI: hi_d = A;
        MD_MTLO: lo_d = A;
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_ok_q <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_ok_q <= pend_ok_d;
    end
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mdu.sv
`default_nettype none
// ============================================================================
// Module  : tb_mdu
// Purpose : Scoreboard testbench for mdu. Stimulus pushes the expected
//           HI/LO and busy length of each multi-cycle op; a monitor pops and
//           compares whenever Busy falls.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mdu;
  import mdu_defs::*;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Start;
  logic [2:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Cancel;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  typedef struct {
    int          id;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .Start  (Start),
    .MDOp   (MDOp),
    .A      (A),
    .B      (B),
    .Cancel (Cancel),
    .Busy   (Busy),
    .HI     (HI),
    .LO     (LO)
  );

  always #5 Clk = ~Clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic expect_op(input int id, input logic [31:0] hi, input logic [31:0] lo, input int cyc);
    exp_t e;
    e.id = id; e.hi = hi; e.lo = lo; e.cyc = cyc;
    sb_q.push_back(e);
  endtask

  // Drive one issue cycle; returns at the following negedge with Start low.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge Clk);
    Start = 1'b1; MDOp = op; A = a; B = b;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && Busy; i++) @(negedge Clk);
    checks++;
    if (Busy) begin
      errors++;
      $display("FAIL wait_idle: Busy still 1 after 40 cycles, expected 0");
    end
  endtask

  // Monitor: counts sampled busy cycles and checks on each Busy fall.
  initial begin : monitor
    int   run;
    logic prev;
    exp_t e;
    run  = 0;
    prev = 1'b0;
    forever begin
      @(negedge Clk);
      if (Busy) begin
        run++;
      end else begin
        if (prev) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_completion: busy run %0d, expected no op", run);
          end else begin
            e = sb_q.pop_front();
            check32($sformatf("op%0d_busy_cycles", e.id), 32'(run), 32'(e.cyc));
            check32($sformatf("op%0d_HI", e.id), HI, e.hi);
            check32($sformatf("op%0d_LO", e.id), LO, e.lo);
          end
        end
        run = 0;
      end
      prev = Busy;
    end
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin : stim
    Rst = 1'b1; Start = 1'b0; Cancel = 1'b0; MDOp = 3'd0; A = 32'd0; B = 32'd0;
    #12;
    check32("reset_Busy", 32'(Busy), 32'd0);
    check32("reset_HI", HI, 32'd0);
    check32("reset_LO", LO, 32'd0);
    @(negedge Clk);
    Rst = 1'b0;

    // Multiplies
    expect_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
    issue(MD_MULT, 32'hFFFF_FFFE, 32'd3);
    wait_idle();
    expect_op(2, 32'hFFFF_FFFE, 32'h0000_0001, 5);
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle();

    // Divides
    expect_op(3, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle();
    expect_op(4, 32'h0000_0001, 32'hFFFF_FFFD, 10);
    issue(MD_DIV, 32'd7, 32'hFFFF_FFFE);
    wait_idle();
    expect_op(5, 32'd1, 32'd3, 10);
    issue(MD_DIVU, 32'd7, 32'd2);
    wait_idle();
    expect_op(6, 32'd0, 32'h8000_0000, 10);
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle();

    // MTHI/MTLO preload, then divide by zero leaves them untouched
    issue(MD_MTHI, 32'h11, 32'd0);
    check32("mthi_HI", HI, 32'h11);
    check32("mthi_Busy", 32'(Busy), 32'd0);
    issue(MD_MTLO, 32'h22, 32'd0);
    check32("mtlo_LO", LO, 32'h22);
    check32("mtlo_Busy", 32'(Busy), 32'd0);
    expect_op(7, 32'h11, 32'h22, 10);
    issue(MD_DIV, 32'd5, 32'd0);
    wait_idle();

    // Reserved opcode has no effect
    issue(3'd6, 32'h33, 32'h44);
    check32("reserved_Busy", 32'(Busy), 32'd0);
    check32("reserved_HI", HI, 32'h11);
    check32("reserved_LO", LO, 32'h22);

    // Cancel in the 3rd busy cycle
    expect_op(8, 32'h11, 32'h22, 3);
    issue(MD_MULT, 32'd2, 32'd3);
    repeat (2) @(negedge Clk);
    Cancel = 1'b1;
    @(negedge Clk);
    Cancel = 1'b0;
    check32("cancel_Busy", 32'(Busy), 32'd0);

    // Cancel suppresses a same-cycle MTLO
    @(negedge Clk);
    Start = 1'b1; MDOp = MD_MTLO; A = 32'd5; Cancel = 1'b1;
    @(negedge Clk);
    Start = 1'b0; Cancel = 1'b0;
    check32("cancel_mtlo_LO", LO, 32'h22);

    // Cancel on the final counting cycle wins over the commit
    expect_op(9, 32'h11, 32'h22, 5);
    issue(MD_MULT, 32'd2, 32'd3);
    repeat (4) @(negedge Clk);
    Cancel = 1'b1;
    @(negedge Clk);
    Cancel = 1'b0;

    // Start while busy is ignored
    expect_op(10, 32'd0, 32'd6, 5);
    issue(MD_MULT, 32'd2, 32'd3);
    Start = 1'b1; MDOp = MD_MTHI; A = 32'h99;
    @(negedge Clk);
    Start = 1'b0;
    wait_idle();

    // Asynchronous reset mid-operation
    expect_op(11, 32'd0, 32'd0, 2);
    issue(MD_MULT, 32'd7, 32'd9);
    @(negedge Clk);
    #2 Rst = 1'b1;
    #1;
    check32("async_rst_Busy", 32'(Busy), 32'd0);
    check32("async_rst_HI", HI, 32'd0);
    check32("async_rst_LO", LO, 32'd0);
    @(negedge Clk);
    Rst = 1'b0;

    repeat (3) @(negedge Clk);
    check32("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mdu.md
Name: mdu

Overview:
- Multi-cycle multiply/divide unit in the EX stage.
- Consumes the forwarded Rd1/Rd2 operands and control decoded in ID, and owns the architectural HI/LO registers.
- Models fixed MIPS mult/div latency with a busy counter. ID stalls HI/LO-dependent instructions while Busy (or Start) is high.
- An exception cancel input discards in-flight work so that precise exceptions hold.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (must be >= 1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (must be >= 1).

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  reset; asynchronous, active-high.
- Start  input  1  issue qualifier for MDOp; sampled at the rising edge.
- MDOp  input  3  operation code (see package).
- A  input  32  operand rs (forwarded Rd1).
- B  input  32  operand rt (forwarded Rd2).
- Cancel  input  1  exception/eret flush. Kills a pending op and suppresses a same-cycle Start.
- Busy  output  1  operation in flight.
- HI  output  32  architectural HI register.
- LO  output  32  architectural LO register.

Behaviour:
- Reset (async, Rst=1):
  - HI=0, LO=0, Busy=0, counter=0.
  - Pending result registers cleared.
  - Reset mid-operation aborts it with no HI/LO update.
- Accepted issue: Start=1 && !Busy && !Cancel at edge t0, with MDOp in {MULT, MULTU, DIV, DIVU}.
  - The full 64-bit result is computed from A/B as sampled at t0 and latched into pend_hi/pend_lo.
  - The counter is loaded with MULT_CYCLES or DIV_CYCLES; Busy=1 from t0.
- Counting:
  - Counter decrements each edge while Busy.
  - At the edge where the counter goes 1->0: HI<=pend_hi, LO<=pend_lo, Busy<=0.
  - Busy is therefore high for exactly N cycles.
  - The new HI/LO are visible in the first cycle with Busy=0.
- MTHI/MTLO with Start=1 && !Busy && !Cancel: write HI (resp. LO) from A at that edge, 0 latency, Busy stays 0.
- Start while Busy=1: ignored. ID guarantees this never happens; the bench checks it has no effect.
- Cancel=1 while Busy: Busy<=0 and counter<=0 at the next edge; pending result discarded; HI/LO unchanged.
- Cancel=1 with Start=1 in the same cycle: Start ignored, including MTHI/MTLO.
- Cancel on the same edge the counter would reach 0: Cancel wins and no commit occurs.
- Arithmetic:
  - MULT: signed 32x32->64; HI=upper 32 bits, LO=lower 32 bits.
  - MULTU: unsigned 32x32->64, same HI/LO split.
  - DIV: signed. LO=quotient truncated toward zero; HI=remainder, taking the sign of the dividend.
  - DIV overflow case 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - DIVU: unsigned quotient/remainder.
  - Divide by zero (B=0, DIV or DIVU): full DIV_CYCLES latency, no commit, HI/LO unchanged.
- Undefined MDOp codes with Start=1: no effect, Busy stays 0.
- HI/LO reads are combinational from the registers. Forwarding of an MTHI/MTLO in flight is the EX mux's job, not this block's.

Decomposition:
- Package mdu_defs holds:
  - MDOp encodings: MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5 (6, 7 reserved).
  - Counter width constant: clog2 of max(MULT_CYCLES, DIV_CYCLES) + 1.
- One combinational sub-module, mdu_calc:
  - Inputs: MDOp, A, B.
  - Outputs: ResHi, ResLo, DivZero.
  - Keeps the signed/unsigned arithmetic separate from the counter/state logic in mdu.
- State: IDLE/BUSY is encoded by Busy plus the counter; no separate FSM register.

Test Plan:
1. MULT with A=0xFFFFFFFE (-2), B=3 -> Busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
2. MULTU with A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
3. DIV signed cases, each with Busy for 10 cycles:
   - A=-7 (0xFFFFFFF9), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
   - DIVU A=7, B=2 -> LO=3, HI=1.
   - DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
4. DIV by zero, with HI=0x11, LO=0x22 preloaded via MTHI/MTLO (each visible the next cycle, Busy=0) -> Busy for 10 cycles; HI/LO still 0x11/0x22 afterwards.
5. MULT A=2, B=3, then Cancel=1 on the 3rd busy cycle -> Busy=0 at the next edge; HI/LO unchanged.
   - Also: Start (MTLO A=5) with Cancel=1 in the same cycle -> LO unchanged.
6. Start MULT, then in busy cycle 2:
   - Assert Start with MTHI A=0x99 -> ignored; final HI/LO equal the MULT result.
   - Assert Rst asynchronously mid-op -> Busy, HI and LO go to 0 immediately, without waiting for a clock edge.
